// File: rtl/image_window_ctrl_if.sv
// Pixel-stream / window-stream bundle for image_window_ctrl.
//   i_pixel_data / i_pixel_data_valid  : raster pixel stream into the controller
//   o_pixel_data / o_pixel_data_valid  : 3x3 window stream out of the controller
//   o_intr                             : one-cycle pulse, one row consumed
// master = pixel source / window sink side, slave = the controller.
interface image_window_ctrl_if;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;

    modport master (
        output i_pixel_data, i_pixel_data_valid,
        input  o_pixel_data, o_pixel_data_valid, o_intr
    );

    modport slave (
        input  i_pixel_data, i_pixel_data_valid,
        output o_pixel_data, o_pixel_data_valid, o_intr
    );
endinterface

// File: rtl/image_window_ctrl.sv
// image_window_ctrl: writes a raster pixel stream round-robin into four line
// buffers and, once three rows are held, reads three of them in lockstep to
// emit one 3x3 window per cycle. o_intr pulses after each consumed row.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset (line buffer pointers clear
//          synchronously from it, so hold it for at least two edges)
//   bus  - image_window_ctrl_if.slave: pixel in, window out, row interrupt
//
// line_buffer: one row of pixels with independent write and read pointers.
// o_data is a prefetched 3-pixel slice {mem[rp], mem[rp+1], mem[rp+2]}; the
// pointer arithmetic wraps at IMAGE_WIDTH, so the last two slices of a row
// pick up columns 0/1.
module line_buffer #(
    parameter int IMAGE_WIDTH = 512
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [7:0]  i_data,
    input  logic        i_data_valid,
    output logic [23:0] o_data,
    input  logic        i_rd_data
);
    localparam int AW = $clog2(IMAGE_WIDTH);

    logic [7:0]    mem [IMAGE_WIDTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (i_data_valid)
            mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!rstN)
            wr_ptr <= '0;
        else if (i_data_valid)
            wr_ptr <= wr_ptr + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstN)
            rd_ptr <= '0;
        else if (i_rd_data)
            rd_ptr <= rd_ptr + AW'(1);
    end

    assign o_data = {mem[rd_ptr], mem[rd_ptr + AW'(1)], mem[rd_ptr + AW'(2)]};
endmodule

module image_window_ctrl #(
    parameter int IMAGE_WIDTH = 512
) (
    input  logic               clk,
    input  logic               rst,
    image_window_ctrl_if.slave bus
);
    localparam int PW = $clog2(IMAGE_WIDTH);
    localparam int CW = $clog2(4*IMAGE_WIDTH) + 1;

    typedef enum logic {IDLE, RD_BUFFER} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] wrPixelCounter;
    logic [PW-1:0] rdCounter;
    logic [1:0]    wrLineSel;
    logic [1:0]    rdLineSel;
    logic [CW-1:0] totalPixelCount;

    logic          rd_active;
    logic          buf_full;
    logic          wr_accept;
    logic          rd_go;
    logic          row_done;
    logic          lb_rstN;

    logic [3:0]        lb_wr;
    logic [3:0]        lb_rd;
    logic [3:0][23:0]  lb_data;
    logic [1:0]        mid_sel;
    logic [1:0]        bot_sel;
    logic [1:0]        idle_sel;

    assign lb_rstN   = ~rst;
    assign rd_active = (state == RD_BUFFER);
    assign buf_full  = (totalPixelCount == CW'(4*IMAGE_WIDTH));
    // A full store only accepts a pixel if a read frees a slot on the same edge.
    assign wr_accept = bus.i_pixel_data_valid && !(buf_full && !rd_active);
    assign rd_go     = (totalPixelCount >= CW'(3*IMAGE_WIDTH));

    // ---------------- write side ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPixelCounter <= '0;
            wrLineSel      <= '0;
        end else if (wr_accept) begin
            if (wrPixelCounter == PW'(IMAGE_WIDTH-1)) begin
                wrPixelCounter <= '0;
                wrLineSel      <= wrLineSel + 2'd1;
            end else begin
                wrPixelCounter <= wrPixelCounter + PW'(1);
            end
        end
    end

    // ---------------- fill counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            totalPixelCount <= '0;
        else begin
            case ({wr_accept, rd_active})
                2'b10:   totalPixelCount <= totalPixelCount + CW'(1);
                2'b01:   totalPixelCount <= totalPixelCount - CW'(1);
                default: totalPixelCount <= totalPixelCount;
            endcase
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        row_done  = 1'b0;
        case (state)
            IDLE: begin
                if (rd_go)
                    state_nxt = RD_BUFFER;
            end
            RD_BUFFER: begin
                if (rdCounter == PW'(IMAGE_WIDTH-1)) begin
                    row_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdCounter <= '0;
            rdLineSel <= '0;
            bus.o_intr <= 1'b0;
        end else begin
            bus.o_intr <= row_done;
            if (row_done) begin
                rdCounter <= '0;
                rdLineSel <= rdLineSel + 2'd1;
            end else if (rd_active) begin
                rdCounter <= rdCounter + PW'(1);
            end
        end
    end

    // ---------------- line buffers ----------------
    assign mid_sel  = rdLineSel + 2'd1;
    assign bot_sel  = rdLineSel + 2'd2;
    // The fourth buffer is the one being refilled; its read pointer stays put.
    assign idle_sel = rdLineSel + 2'd3;

    for (genvar b = 0; b < 4; b++) begin : g_lb
        assign lb_wr[b] = wr_accept && (wrLineSel == 2'(b));
        assign lb_rd[b] = rd_active && (idle_sel != 2'(b));

        line_buffer #(.IMAGE_WIDTH(IMAGE_WIDTH)) u_lb (
            .clk          (clk),
            .rstN         (lb_rstN),
            .i_data       (bus.i_pixel_data),
            .i_data_valid (lb_wr[b]),
            .o_data       (lb_data[b]),
            .i_rd_data    (lb_rd[b])
        );
    end

    assign bus.o_pixel_data_valid = rd_active;
    assign bus.o_pixel_data       = {lb_data[rdLineSel], lb_data[mid_sel], lb_data[bot_sel]};
endmodule

// File: tb/tb_image_window_ctrl.sv
module tb_image_window_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    image_window_ctrl_if bus();

    image_window_ctrl #(.IMAGE_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: every pixel the source sends (flow-controlled, so all
    // are accepted) in raster order; row n is px[n*W +: W]. The m-th row read
    // windows rows m, m+1, m+2; window k takes columns k..k+2 mod W.
    byte unsigned px[$];
    int  m = 0;
    int  k = 0;
    bit  exp_intr = 1'b0;
    bit  mon_en = 1'b1;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] w9(input int t0, t1, t2, m0, m1, m2, b0, b1, b2);
        return {8'(t0), 8'(t1), 8'(t2), 8'(m0), 8'(m1), 8'(m2), 8'(b0), 8'(b1), 8'(b2)};
    endfunction

    function automatic logic [71:0] model_win(input int row, input int col);
        logic [71:0] w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w = {w[63:0], px[(row + r)*W + (col + c) % W]};
        return w;
    endfunction

    // Window stream monitor against the model.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("intr", bus.o_intr, exp_intr);
            if (exp_intr)
                chk("idle_after_row", bus.o_pixel_data_valid, 1'b0);
            exp_intr = 1'b0;
            if (bus.o_pixel_data_valid === 1'b1) begin
                if (px.size() < (m + 3)*W)
                    chk("early_window", bus.o_pixel_data_valid, 1'b0);
                else
                    chk("window", bus.o_pixel_data, model_win(m, k));
                k++;
                if (k == W) begin
                    k = 0;
                    m++;
                    exp_intr = 1'b1;
                end
            end else if (k != 0) begin
                chk("row_gap", bus.o_pixel_data_valid, 1'b1);
                k = 0;
                m++;
            end
        end
    end

    task automatic step(input bit v, input byte unsigned d);
        bus.i_pixel_data_valid = v;
        bus.i_pixel_data       = d;
        if (v)
            px.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.i_pixel_data_valid = 1'($urandom);
            bus.i_pixel_data       = 8'($urandom);
            @(posedge clk);
            #1;
            chk("rst_valid", bus.o_pixel_data_valid, 1'b0);
            chk("rst_intr", bus.o_intr, 1'b0);
        end
        px.delete();
        m = 0;
        k = 0;
        exp_intr = 1'b0;
        bus.i_pixel_data_valid = 1'b0;
        bus.i_pixel_data = 8'h00;
        rst = 1'b0;
    endtask

    // Pixels 1..24 then the first row of windows; ends in the o_intr cycle.
    task automatic fill_first(input string tag);
        for (int p = 1; p <= 24; p++) begin
            step(1'b1, 8'(p));
            chk({tag, "_nowin"}, bus.o_pixel_data_valid, 1'b0);
        end
        step(1'b0, 8'h00);
        chk({tag, "_valid_rise"}, bus.o_pixel_data_valid, 1'b1);
        chk({tag, "_win0"}, bus.o_pixel_data, w9(1, 2, 3, 9, 10, 11, 17, 18, 19));
        repeat (6) step(1'b0, 8'h00);
        chk({tag, "_win6"}, bus.o_pixel_data, w9(7, 8, 1, 15, 16, 9, 23, 24, 17));
        step(1'b0, 8'h00);
        chk({tag, "_win7_valid"}, bus.o_pixel_data_valid, 1'b1);
        chk({tag, "_win7"}, bus.o_pixel_data, w9(8, 1, 2, 16, 9, 10, 24, 17, 18));
        step(1'b0, 8'h00);
        chk({tag, "_valid_fall"}, bus.o_pixel_data_valid, 1'b0);
        chk({tag, "_intr"}, bus.o_intr, 1'b1);
        chk({tag, "_cnt16"}, dut.totalPixelCount, 16);
    endtask

    initial begin
        int rows_sent;
        int t;
        bus.i_pixel_data_valid = 1'b0;
        bus.i_pixel_data = 8'h00;
        rst = 1'b1;

        // Reset and first row
        do_reset(3);
        chk("rst_cnt", dut.totalPixelCount, 0);
        fill_first("fill");

        // Rolling rows: pixels 25..32 go to buffer 3
        for (int p = 25; p <= 32; p++) step(1'b1, 8'(p));
        chk("roll_wrsel", dut.wrLineSel, 0);
        chk("roll_nowin", bus.o_pixel_data_valid, 1'b0);
        step(1'b0, 8'h00);
        chk("roll_valid", bus.o_pixel_data_valid, 1'b1);
        chk("roll_win0", bus.o_pixel_data, w9(9, 10, 11, 17, 18, 19, 25, 26, 27));
        chk("roll_rdsel", dut.rdLineSel, 1);
        repeat (8) step(1'b0, 8'h00);
        chk("roll_intr", bus.o_intr, 1'b1);

        // Write-select wrap: pixels 33..40 land in buffer 0
        for (int p = 33; p <= 40; p++) step(1'b1, 8'(p));
        chk("wrap_wrsel", dut.wrLineSel, 1);
        chk("wrap_wrcnt", dut.wrPixelCounter, 0);
        step(1'b0, 8'h00);
        chk("wrap_win0", bus.o_pixel_data, w9(17, 18, 19, 25, 26, 27, 33, 34, 35));
        chk("wrap_rdsel", dut.rdLineSel, 2);
        repeat (8) step(1'b0, 8'h00);
        chk("wrap_cnt", dut.totalPixelCount, 16);

        // Overflow with the reader held in IDLE
        mon_en = 1'b0;
        do_reset(3);
        force dut.rd_go = 1'b0;
        for (int p = 1; p <= 32; p++) step(1'b1, 8'(p));
        step(1'b0, 8'h00);
        chk("ovf_cnt_full", dut.totalPixelCount, 32);
        step(1'b1, 8'd99);
        chk("ovf_drop_cnt", dut.totalPixelCount, 32);
        chk("ovf_drop_wrcnt", dut.wrPixelCounter, 0);
        chk("ovf_drop_wrsel", dut.wrLineSel, 0);
        chk("ovf_no_valid", bus.o_pixel_data_valid, 1'b0);
        release dut.rd_go;
        step(1'b0, 8'h00);
        chk("ovf_read_start", bus.o_pixel_data_valid, 1'b1);
        chk("ovf_not_written", bus.o_pixel_data, w9(1, 2, 3, 9, 10, 11, 17, 18, 19));
        step(1'b1, 8'd99);
        chk("simul_cnt", dut.totalPixelCount, 32);
        chk("simul_wrcnt", dut.wrPixelCounter, 1);
        repeat (2) step(1'b0, 8'h00);
        chk("mid_4th_window", bus.o_pixel_data, w9(4, 5, 6, 12, 13, 14, 20, 21, 22));

        // Reset during the 4th window
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.o_pixel_data_valid, 1'b0);
        chk("mid_rst_state", dut.state, 0);
        chk("mid_rst_cnt", dut.totalPixelCount, 0);
        chk("mid_rst_wrcnt", dut.wrPixelCounter, 0);
        chk("mid_rst_wrsel", dut.wrLineSel, 0);
        chk("mid_rst_rdcnt", dut.rdCounter, 0);
        chk("mid_rst_rdsel", dut.rdLineSel, 0);
        do_reset(3);
        mon_en = 1'b1;
        fill_first("refill");

        // Randomized rows, source throttled to at most four rows in flight
        rows_sent = 3;
        for (int r = 0; r < 14; r++) begin
            t = 0;
            while (rows_sent - m > 3 && t < 200) begin
                step(1'b0, 8'h00);
                t++;
            end
            chk("throttle_wait", 1'(rows_sent - m <= 3), 1'b1);
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(3) == 0) step(1'b0, 8'h00);
                step(1'b1, 8'($urandom));
            end
            rows_sent++;
        end
        t = 0;
        while (m < rows_sent - 2 && t < 500) begin
            step(1'b0, 8'h00);
            t++;
        end
        repeat (3) step(1'b0, 8'h00);
        chk("rows_consumed", m, rows_sent - 2);
        chk("final_cnt", dut.totalPixelCount, 2*W);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/image_window_ctrl.md
Name: image_window_ctrl

Overview:
- Writer/reader controller that sits in front of the line buffers.
- Accepts a raster pixel stream and writes it round-robin into four internal line_buffer instances.
- Once three full rows are buffered, reads three of them in lockstep to emit one 3x3 pixel window per cycle to the downstream convolution/Sobel stage.
- Pulses an interrupt each time a row has been consumed, so the upstream source can send another row.

Parameters:
- IMAGE_WIDTH, 512, pixels per row. Must be a power of 2 ≥ 4, and must match the line_buffer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_pixel_data  input  8  incoming pixel, raster order.
- i_pixel_data_valid  input  1  i_pixel_data is valid this cycle.
- o_pixel_data  output  72  3x3 window: [71:48] top row, [47:24] middle row, [23:0] bottom row. Each row is {p[c], p[c+1], p[c+2]}, with p[c] in the MSB byte.
- o_pixel_data_valid  output  1  o_pixel_data holds a window this cycle.
- o_intr  output  1  one-cycle pulse: one row has been fully consumed.

Behaviour:
- Clock and reset:
  - One clock domain.
  - All controller registers reset asynchronously on rst=1.
  - Line buffer pointers are driven rstN = ~rst and reset synchronously.
  - rst must therefore stay high for ≥2 clk edges.
- Reset values:
  - o_pixel_data_valid=0, o_intr=0, FSM=IDLE.
  - wrPixelCounter, wrLineSel, rdCounter, rdLineSel and totalPixelCount are all 0.
  - o_pixel_data is don't-care while valid=0.
- Write side:
  - An accepted pixel is written to line buffer wrLineSel (its i_data_valid asserted) and increments wrPixelCounter.
  - When wrPixelCounter==IMAGE_WIDTH-1 and a pixel is accepted: wrPixelCounter→0 and wrLineSel→(wrLineSel+1) mod 4.
- Fill counter:
  - totalPixelCount has width $clog2(4*IMAGE_WIDTH)+1.
  - +1 per accepted write, −1 per read cycle; a simultaneous write and read leaves it unchanged.
- Overflow:
  - If totalPixelCount==4*IMAGE_WIDTH and no read is occurring this cycle, the input pixel is dropped: no buffer write, no counter change.
  - Upstream is expected to throttle on o_intr; dropping is a protection mechanism only.
- Read FSM, IDLE→RD_BUFFER:
  - Taken when totalPixelCount ≥ 3*IMAGE_WIDTH.
  - The comparison uses the registered count, so the earliest entry is one cycle after the count reaches the threshold.
- Read FSM, in RD_BUFFER:
  - o_pixel_data_valid=1; it is decoded directly from the state register.
  - rd_enable is asserted to the three selected buffers only, and rdCounter increments.
- Read FSM, RD_BUFFER→IDLE:
  - Taken at the edge where rdCounter==IMAGE_WIDTH-1.
  - On that edge: rdCounter→0, rdLineSel→(rdLineSel+1) mod 4, and o_intr is registered high for exactly the next cycle.
- Back-to-back rows:
  - Every row read leaves at least one IDLE cycle, because the threshold is re-checked in IDLE.
  - IDLE→RD_BUFFER may be taken in the same cycle that o_intr is high.
- Row mapping:
  - Top = buffer rdLineSel, middle = (rdLineSel+1) mod 4, bottom = (rdLineSel+2) mod 4.
  - Data is combinational from the line buffers' prefetched outputs; there is zero cycles of latency from valid to data.
- Row consumption and wrap:
  - Exactly IMAGE_WIDTH reads are issued per row, keeping the line-buffer read pointers row-aligned.
  - The last two windows of each row contain wrapped columns (c+1 or c+2 ≥ IMAGE_WIDTH wraps to 0/1); downstream discards them.
- Reset mid-operation: FSM returns to IDLE and all counters clear; buffered data is treated as lost.

Test Plan (IMAGE_WIDTH=8):
- Reset:
  - Stimulus: hold rst=1 for 3 cycles with random i_pixel_data_valid.
  - Required: o_pixel_data_valid=0, o_intr=0; no window is emitted after release until 24 pixels have been sent.
- Fill and first row:
  - Stimulus: stream pixels 1..24 contiguously.
  - Required: o_pixel_data_valid rises 2 cycles after the 24th pixel's valid cycle and stays high for 8 cycles.
  - Required: first window = {1,2,3, 9,10,11, 17,18,19}; window 6 = {7,8,1, 15,16,9, 23,24,17}; window 7 = {8,1,2, 16,9,10, 24,17,18}.
  - Required: o_intr is high the cycle after the last valid, and totalPixelCount=16.
- Rolling rows:
  - Stimulus: after the first o_intr, send pixels 25..32.
  - Required: the next row's first window = {9,10,11, 17,18,19, 25,26,27}.
  - Required: rdLineSel=1; buffer 3 was written.
- Write-select wrap:
  - Stimulus: send 40 pixels total, with the reader consuming rows as they become available.
  - Required: pixels 33..40 land in buffer 0 (wrLineSel wraps 3→0).
  - Required: the window top/middle/bottom rows come from buffers 2, 3, 0.
- Overflow and simultaneous events:
  - Stimulus: fill 32 pixels with the reader held off (read-side FSM forced to IDLE via force), then send pixel 99.
  - Required: pixel 99 is dropped and the count stays 32.
  - Stimulus: send pixel 99 in a cycle where a read also occurs.
  - Required: the pixel is accepted and the count is unchanged.
- Reset mid-row:
  - Stimulus: assert rst during the 4th window of a row.
  - Required: valid drops immediately (asynchronous), FSM=IDLE, all counters 0.
  - Required: the next 24 pixels reproduce the exact first-window sequence of the "Fill and first row" scenario.
